// File: rtl/gp_pkg.sv
// gp_pkg: shared graphics-processor widths, screen limits, opcodes and command record.
package gp_pkg;
  localparam int GP_X_W = 10;
  localparam int GP_Y_W = 9;
  localparam int GP_ARG_W = 12;
  localparam int SCREEN_MAX_X = 639;
  localparam int SCREEN_MAX_Y = 479;
  localparam logic OP_FILL = 1'b0;
  localparam logic OP_BLIT = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} arb_state_t;

  typedef struct packed {
    logic                opcode;
    logic [GP_X_W-1:0]   tl_x;
    logic [GP_Y_W-1:0]   tl_y;
    logic [GP_X_W-1:0]   br_x;
    logic [GP_Y_W-1:0]   br_y;
    logic [GP_ARG_W-1:0] arg;
  } gp_cmd_t;

  // Only the bottom-right corner is limited; an inverted rectangle passes through untouched.
  function automatic gp_cmd_t clamp_cmd(input gp_cmd_t c);
    gp_cmd_t r;
    r = c;
    r.br_x = c.br_x > GP_X_W'(SCREEN_MAX_X) ? GP_X_W'(SCREEN_MAX_X) : c.br_x;
    r.br_y = c.br_y > GP_Y_W'(SCREEN_MAX_Y) ? GP_Y_W'(SCREEN_MAX_Y) : c.br_y;
    return r;
  endfunction
endpackage

// File: rtl/gp_rr_pick.sv
// gp_rr_pick: combinational rotating-priority picker; first set request at or after ptr.
module gp_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         valid,
  output logic [2:0]   idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [3:0]     off;
  logic [3:0]     sum;

  // rot[k] is the request sitting k positions after ptr
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  assign valid = |req;

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) off = 4'(k);
    sum = 4'(ptr) + off;
    idx = 3'(sum >= 4'(N) ? sum - 4'(N) : sum);
  end
endmodule

// File: rtl/gp_arbiter.sv
// gp_arbiter: round-robin sharing of the GP rectangle engine among NUM_REQ requesters,
// with command latch at grant, optional screen clamp and optional BUSY watchdog.
module gp_arbiter
  import gp_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter bit CLAMP_EN = 1'b1,
  parameter int TIMEOUT  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_en,
  input  logic [NUM_REQ-1:0]          req_opcode,
  input  logic [NUM_REQ*GP_X_W-1:0]   req_tl_x,
  input  logic [NUM_REQ*GP_Y_W-1:0]   req_tl_y,
  input  logic [NUM_REQ*GP_X_W-1:0]   req_br_x,
  input  logic [NUM_REQ*GP_Y_W-1:0]   req_br_y,
  input  logic [NUM_REQ*GP_ARG_W-1:0] req_arg,
  output logic [NUM_REQ-1:0]          req_finish,
  output logic [NUM_REQ-1:0]          req_err,
  output logic                        gp_en,
  output logic                        gp_opcode,
  output logic [GP_X_W-1:0]           gp_tl_x,
  output logic [GP_Y_W-1:0]           gp_tl_y,
  output logic [GP_X_W-1:0]           gp_br_x,
  output logic [GP_Y_W-1:0]           gp_br_y,
  output logic [GP_ARG_W-1:0]         gp_arg,
  input  logic                        gp_finish,
  output logic                        busy,
  output logic [2:0]                  grant_id
);
  arb_state_t state, state_nx;
  logic [2:0] rr_ptr, pick_idx;
  logic [31:0] wdog;
  logic pick_valid, issue, fin, tout, rel;
  logic [NUM_REQ-1:0] gnt_oh;
  gp_cmd_t sel, cmd;

  gp_rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req_en),
    .ptr(rr_ptr),
    .valid(pick_valid),
    .idx(pick_idx)
  );

  assign gnt_oh = NUM_REQ'(1) << grant_id;
  assign busy = state != ST_IDLE;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_idx == 3'(i))
        sel = '{opcode: req_opcode[i],
                tl_x: req_tl_x[GP_X_W*i +: GP_X_W],
                tl_y: req_tl_y[GP_Y_W*i +: GP_Y_W],
                br_x: req_br_x[GP_X_W*i +: GP_X_W],
                br_y: req_br_y[GP_Y_W*i +: GP_Y_W],
                arg: req_arg[GP_ARG_W*i +: GP_ARG_W]};
    cmd = CLAMP_EN ? clamp_cmd(sel) : sel;
  end

  // A real completion wins over a watchdog expiry in the same cycle
  always_comb begin
    issue = state == ST_IDLE && pick_valid && !gp_finish;
    tout = state == ST_BUSY && TIMEOUT != 0 && wdog == 32'(TIMEOUT - 1) && !gp_finish;
    fin = state == ST_BUSY && (gp_finish || tout);
    rel = state == ST_DONE && !(|(req_en & gnt_oh)) && !gp_finish;
    state_nx = issue ? ST_BUSY : fin ? ST_DONE : rel ? ST_IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gp_en <= 1'b0;
      {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg} <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
      wdog <= '0;
      req_finish <= '0;
      req_err <= '0;
    end else begin
      if (issue) begin
        {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg} <= cmd;
        gp_en <= 1'b1;
        grant_id <= pick_idx;
        wdog <= '0;
      end
      if (state == ST_BUSY) wdog <= wdog + 32'd1;
      if (fin) begin
        gp_en <= 1'b0;
        req_finish <= gnt_oh;
        req_err <= tout ? gnt_oh : '0;
      end
      if (rel) begin
        req_finish <= '0;
        req_err <= '0;
        rr_ptr <= grant_id == 3'(NUM_REQ - 1) ? 3'd0 : grant_id + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_gp_arbiter.sv
// tb_gp_arbiter: table-driven and sequence checks of gp_arbiter against a grant scoreboard;
// a second instance without clamp or watchdog runs in lockstep on the same inputs.
module tb_gp_arbiter;
  import gp_pkg::*;
  localparam int N = 3;

  typedef struct {
    int          id;
    logic        op;
    logic [9:0]  tlx;
    logic [8:0]  tly;
    logic [9:0]  brx;
    logic [8:0]  bry;
    logic [11:0] arg;
    logic [9:0]  ebx;
    logic [8:0]  eby;
  } vec_t;

  logic clk = 1'b0, rst_n;
  logic [N-1:0] req_en, req_opcode;
  logic [N*10-1:0] req_tl_x, req_br_x;
  logic [N*9-1:0] req_tl_y, req_br_y;
  logic [N*12-1:0] req_arg;
  logic gp_finish;
  logic [N-1:0] req_finish, req_err, req_finish_nc, req_err_nc;
  logic gp_en, gp_opcode, busy, gp_en_nc, gp_opcode_nc, busy_nc;
  logic [9:0] gp_tl_x, gp_br_x, gp_tl_x_nc, gp_br_x_nc;
  logic [8:0] gp_tl_y, gp_br_y, gp_tl_y_nc, gp_br_y_nc;
  logic [11:0] gp_arg, gp_arg_nc;
  logic [2:0] grant_id, grant_id_nc;

  int n_tests = 0, n_fail = 0;
  int gp_lat = 4;
  logic gp_hang = 1'b0, gp_stuck = 1'b0;
  vec_t sb[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  gp_arbiter #(.NUM_REQ(N), .CLAMP_EN(1'b1), .TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_opcode(req_opcode),
    .req_tl_x(req_tl_x), .req_tl_y(req_tl_y), .req_br_x(req_br_x), .req_br_y(req_br_y),
    .req_arg(req_arg), .req_finish(req_finish), .req_err(req_err), .gp_en(gp_en),
    .gp_opcode(gp_opcode), .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x),
    .gp_br_y(gp_br_y), .gp_arg(gp_arg), .gp_finish(gp_finish), .busy(busy),
    .grant_id(grant_id)
  );

  gp_arbiter #(.NUM_REQ(N), .CLAMP_EN(1'b0), .TIMEOUT(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_opcode(req_opcode),
    .req_tl_x(req_tl_x), .req_tl_y(req_tl_y), .req_br_x(req_br_x), .req_br_y(req_br_y),
    .req_arg(req_arg), .req_finish(req_finish_nc), .req_err(req_err_nc), .gp_en(gp_en_nc),
    .gp_opcode(gp_opcode_nc), .gp_tl_x(gp_tl_x_nc), .gp_tl_y(gp_tl_y_nc),
    .gp_br_x(gp_br_x_nc), .gp_br_y(gp_br_y_nc), .gp_arg(gp_arg_nc),
    .gp_finish(gp_finish), .busy(busy_nc), .grant_id(grant_id_nc)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic go(input vec_t v);
    req_opcode[v.id] = v.op;
    req_tl_x[10*v.id +: 10] = v.tlx;
    req_tl_y[9*v.id +: 9] = v.tly;
    req_br_x[10*v.id +: 10] = v.brx;
    req_br_y[9*v.id +: 9] = v.bry;
    req_arg[12*v.id +: 12] = v.arg;
    sb.push_back(v);
  endtask

  task automatic wait_fin(input logic [N-1:0] mask);
    int n = 0;
    while (!(|(req_finish & mask)) && n < 300) begin @(negedge clk); n++; end
    check("wait_fin", 32'(|(req_finish & mask)), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("wait_idle", 32'(busy), 0);
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (!gp_en && n < 300) begin @(negedge clk); n++; end
    check("wait_gnt", 32'(gp_en), 1);
  endtask

  // GP model: finishes gp_lat cycles after gp_en, holds finish until gp_en falls
  initial begin
    int cnt = 0;
    gp_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (gp_stuck) gp_finish = 1'b1;
      else if (!gp_en) begin gp_finish = 1'b0; cnt = 0; end
      else if (!gp_hang) begin cnt++; if (cnt >= gp_lat) gp_finish = 1'b1; end
    end
  end

  // Grant monitor: every rising gp_en must match the oldest expected command
  initial begin
    logic prev = 1'b0;
    vec_t e;
    forever begin
      @(negedge clk);
      if (gp_en && !prev) begin
        if (sb.size() == 0) check("unexpected_grant", 32'(gp_en), 0);
        else begin
          e = sb.pop_front();
          check("grant_id", 32'(grant_id), 32'(e.id));
          check("opcode", 32'(gp_opcode), 32'(e.op));
          check("tl_x", 32'(gp_tl_x), 32'(e.tlx));
          check("tl_y", 32'(gp_tl_y), 32'(e.tly));
          check("br_x", 32'(gp_br_x), 32'(e.ebx));
          check("br_y", 32'(gp_br_y), 32'(e.eby));
          check("arg", 32'(gp_arg), 32'(e.arg));
          check("br_x_noclamp", 32'(gp_br_x_nc), 32'(e.brx));
          check("br_y_noclamp", 32'(gp_br_y_nc), 32'(e.bry));
        end
      end
      prev = gp_en;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vec_t v, r2[3];
    int cnt;
    tbl[0] = '{0, OP_FILL, 10'd0, 9'd0, 10'd639, 9'd479, 12'hFFF, 10'd639, 9'd479};
    tbl[1] = '{1, OP_BLIT, 10'd5, 9'd6, 10'd700, 9'd500, 12'h123, 10'd639, 9'd479};
    tbl[2] = '{2, OP_FILL, 10'd10, 9'd20, 10'd640, 9'd480, 12'hABC, 10'd639, 9'd479};
    tbl[3] = '{0, OP_BLIT, 10'd1023, 9'd511, 10'd1023, 9'd511, 12'h000, 10'd639, 9'd479};
    tbl[4] = '{1, OP_FILL, 10'd300, 9'd200, 10'd100, 9'd50, 12'h5A5, 10'd100, 9'd50};
    tbl[5] = '{2, OP_BLIT, 10'd0, 9'd0, 10'd638, 9'd478, 12'h001, 10'd638, 9'd478};
    r2[0] = '{0, OP_FILL, 10'd1, 9'd1, 10'd2, 9'd2, 12'h111, 10'd2, 9'd2};
    r2[1] = '{1, OP_BLIT, 10'd3, 9'd3, 10'd4, 9'd4, 12'h222, 10'd4, 9'd4};
    r2[2] = '{2, OP_FILL, 10'd5, 9'd5, 10'd6, 9'd6, 12'h333, 10'd6, 9'd6};
    req_en = '0; req_opcode = '0; req_tl_x = '0; req_tl_y = '0;
    req_br_x = '0; req_br_y = '0; req_arg = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gp_en", 32'(gp_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_req_finish", 32'(req_finish), 0);
    check("rst_req_err", 32'(req_err), 0);
    check("rst_gp_br_x", 32'(gp_br_x), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single full-screen fill, 1-cycle grant latency, finish held until en drops
    gp_lat = 20;
    go(tbl[0]);
    req_en = 3'b001;
    #1 check("t1_pre_grant", 32'(gp_en), 0);
    @(negedge clk);
    check("t1_latency", 32'(gp_en), 1);
    check("t1_busy", 32'(busy), 1);
    wait_fin(3'b001);
    check("t1_finish", 32'(req_finish), 32'b001);
    check("t1_gp_en_low", 32'(gp_en), 0);
    repeat (3) @(negedge clk);
    check("t1_hold", 32'(req_finish), 32'b001);
    req_en = 3'b000;
    @(negedge clk);
    check("t1_release", 32'(req_finish), 0);
    check("t1_idle", 32'(busy), 0);
    gp_lat = 4;

    for (int i = 0; i < 6; i++) begin
      wait_idle();
      go(tbl[i]);
      req_en[tbl[i].id] = 1'b1;
      wait_fin(3'(1 << tbl[i].id));
      check("tbl_finish", 32'(req_finish), 32'(1 << tbl[i].id));
      check("tbl_err", 32'(req_err), 0);
      req_en[tbl[i].id] = 1'b0;
      @(negedge clk);
    end
    wait_idle();

    // round robin from rr_ptr=0, twice
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) go(r2[k]);
      req_en = 3'b111;
      for (int k = 0; k < 3; k++) begin
        wait_fin(3'b111);
        check("t2_order", 32'(req_finish), 32'(1 << k));
        req_en[k] = 1'b0;
        @(negedge clk);
      end
      wait_idle();
    end

    // field changes and abort while BUSY
    gp_lat = 10;
    v = '{0, OP_BLIT, 10'd100, 9'd50, 10'd200, 9'd100, 12'h777, 10'd200, 9'd100};
    go(v);
    req_en = 3'b001;
    wait_gnt();
    req_tl_x[9:0] = 10'd999;
    repeat (2) @(negedge clk);
    check("t4_tl_stable", 32'(gp_tl_x), 100);
    check("t4_still_busy", 32'(gp_en), 1);
    req_en = 3'b000;
    wait_fin(3'b001);
    check("t4_abort_finish", 32'(req_finish), 32'b001);
    @(negedge clk);
    wait_idle();
    v = '{1, OP_FILL, 10'd7, 9'd7, 10'd8, 9'd8, 12'h444, 10'd8, 9'd8};
    go(v);
    req_en = 3'b010;
    wait_fin(3'b010);
    req_en = 3'b000;
    @(negedge clk);
    wait_idle();
    gp_lat = 4;

    // watchdog expiry, then stale gp_finish in IDLE
    gp_hang = 1'b1;
    v = '{2, OP_BLIT, 10'd1, 9'd2, 10'd3, 9'd4, 12'h0F0, 10'd3, 9'd4};
    go(v);
    req_en = 3'b100;
    wait_gnt();
    cnt = 0;
    while (gp_en && cnt < 100) begin @(negedge clk); cnt++; end
    check("t5_timeout_cycles", 32'(cnt), 50);
    check("t5_finish", 32'(req_finish), 32'b100);
    check("t5_err", 32'(req_err), 32'b100);
    check("t5_nc_no_wdog", 32'(gp_en_nc), 1);
    req_en = 3'b000;
    @(negedge clk);
    wait_idle();
    check("t5_err_clear", 32'(req_err), 0);
    gp_stuck = 1'b1;
    repeat (2) @(negedge clk);
    req_en = 3'b001;
    repeat (10) @(negedge clk);
    check("t5_stale_block", 32'(gp_en), 0);
    check("t5_stale_idle", 32'(busy), 0);
    req_en = 3'b000;
    @(negedge clk);
    gp_stuck = 1'b0;
    gp_hang = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset mid-BUSY
    v = '{2, OP_FILL, 10'd11, 9'd22, 10'd33, 9'd44, 12'h321, 10'd33, 9'd44};
    go(v);
    req_en = 3'b100;
    wait_gnt();
    #2 rst_n = 1'b0;
    #1;
    check("t6_gp_en", 32'(gp_en), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_grant_id", 32'(grant_id), 0);
    check("t6_tl_x", 32'(gp_tl_x), 0);
    check("t6_arg", 32'(gp_arg), 0);
    check("t6_nc_gp_en", 32'(gp_en_nc), 0);
    @(negedge clk);
    v = '{1, OP_BLIT, 10'd7, 9'd8, 10'd9, 9'd10, 12'hABC, 10'd9, 9'd10};
    go(v);
    req_en = 3'b010;
    rst_n = 1'b1;
    wait_fin(3'b010);
    check("t6_regrant", 32'(grant_id), 1);
    req_en = 3'b000;
    @(negedge clk);
    wait_idle();

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
